counter_ctrl: RTL and testbench

Upstream sequencer and checker for the 4-bit `counter` block. On a start request it clears the counter, holds `enable` for a programmed number of cycles, then verifies the counter's final and intermediate values against an internal shadow model. It reports pass/fail and keeps a saturating error tally. It sits between a host/test controller and `counter`, driving the counter's `reset`/`enable` and consuming its `count`.

---
 rtl/counter_pkg.sv | 16 +
 rtl/cnt_shadow.sv | 27 ++
 rtl/counter_ctrl.sv | 121 ++++++++++++
 tb/tb_counter_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the counter block and its sequencer/checker.
package counter_pkg;

    localparam int CNT_WIDTH = 4;
    localparam int DEF_LEN_W = 8;
    localparam int DEF_ERR_W = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLR    = 3'd1,
        RUN    = 3'd2,
        SETTLE = 3'd3,
        DONE   = 3'd4
    } ctrl_state_t;

endpackage

// File: rtl/cnt_shadow.sv
// Clear/enable model counter; tracks what a correct counter should hold.
import counter_pkg::*;

module cnt_shadow #(
    parameter int WIDTH = CNT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] value
);

    // Model counter; clear has priority, wraps naturally at 2^WIDTH
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (en) begin
            value <= value + WIDTH'(1);
        end else begin
            value <= value;
        end
    end

endmodule

// File: rtl/counter_ctrl.sv
// Sequencer/checker for the counter: clears it, enables it for len cycles,
// checks every intermediate and the final value, and tallies failed runs.
import counter_pkg::*;

module counter_ctrl #(
    parameter int WIDTH = CNT_WIDTH,
    parameter int LEN_W = DEF_LEN_W,
    parameter int ERR_W = DEF_ERR_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [WIDTH-1:0] count,
    output logic             cnt_clr,
    output logic             cnt_en,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count
);

    ctrl_state_t      state_r;
    ctrl_state_t      state_s;
    logic [LEN_W-1:0] rem_r;
    logic [LEN_W-1:0] len_r;
    logic             mism_r;
    logic [WIDTH-1:0] exp_s;
    logic             mismatch_s;

    cnt_shadow #(.WIDTH(WIDTH)) u_shadow (
        .clk   (clk),
        .reset (reset),
        .clr   (state_r == CLR),
        .en    (state_r == RUN),
        .value (exp_s)
    );

    assign mismatch_s = ((state_r == RUN) || (state_r == SETTLE)) && (count != exp_s);

    // Next-state decode
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) state_s = CLR;
                else       state_s = IDLE;
            end
            CLR: begin
                if (rem_r != '0) state_s = RUN;
                else             state_s = SETTLE;
            end
            RUN: begin
                if (rem_r == LEN_W'(1)) state_s = SETTLE;
                else                    state_s = RUN;
            end
            SETTLE:  state_s = DONE;
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register and outputs registered from the next state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_clr <= 1'b0;
            cnt_en  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_clr <= (state_s == CLR);
            cnt_en  <= (state_s == RUN);
            busy    <= (state_s != IDLE);
            done    <= (state_s == DONE);
        end
    end

    // Run length, mismatch monitor, verdict and saturating error tally
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem_r     <= '0;
            len_r     <= '0;
            mism_r    <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        rem_r <= len;
                        len_r <= len;
                        pass  <= 1'b0;
                    end
                end
                CLR: begin
                    mism_r <= 1'b0;
                end
                RUN: begin
                    if (rem_r != '0) rem_r <= rem_r - LEN_W'(1);
                    mism_r <= mism_r | mismatch_s;
                end
                SETTLE: begin
                    // Fold in this cycle's compare so a last-cycle slip is not missed
                    pass   <= !(mism_r || mismatch_s) && (count == len_r[WIDTH-1:0]);
                    mism_r <= mism_r | mismatch_s;
                end
                DONE: begin
                    if (!pass && (err_count != {ERR_W{1'b1}})) begin
                        err_count <= err_count + ERR_W'(1);
                    end
                end
                default: begin
                    rem_r <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed bench for counter_ctrl driving a behavioural counter with an
// optional skipped-increment fault.
module tb_counter_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] len;
    logic [3:0] count;
    logic       cnt_clr;
    logic       cnt_en;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] err_count;

    logic       fault_mode;
    int         inc_idx;
    int         n_asserts = 0;
    int         n_fail = 0;
    int         dc;
    int         ec;
    int         bc;

    always #5 clk = ~clk;

    counter_ctrl #(.WIDTH(4), .LEN_W(8), .ERR_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .len       (len),
        .count     (count),
        .cnt_clr   (cnt_clr),
        .cnt_en    (cnt_en),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count)
    );

    // Counter under test; in fault mode it drops the third increment of a run
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count   <= 4'd0;
            inc_idx <= 0;
        end else if (cnt_clr) begin
            count   <= 4'd0;
            inc_idx <= 0;
        end else if (cnt_en) begin
            if (!(fault_mode && inc_idx == 2)) count <= count + 4'd1;
            inc_idx <= inc_idx + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_asserts++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Launch one run; returns first done cycle (0 on timeout) and enable/busy cycle counts.
    // poke > 0 pulses start and rewrites len at that cycle of the run.
    task automatic run_len(input logic [7:0] l, input bit flt, input int poke,
                           output int done_cyc, output int en_cyc, output int busy_cyc);
        fault_mode = flt;
        @(negedge clk);
        start = 1'b1;
        len   = l;
        done_cyc = 0;
        en_cyc   = 0;
        busy_cyc = 0;
        for (int k = 1; k <= int'(l) + 10; k++) begin
            @(negedge clk);
            en_cyc   += int'(cnt_en);
            busy_cyc += int'(busy);
            if (k == poke) begin
                start = 1'b1;
                len   = 8'd2;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                done_cyc = k;
                break;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        len        = 8'd0;
        fault_mode = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 32'd0);
        chk("rst_done", done, 32'd0);
        chk("rst_en", cnt_en, 32'd0);
        chk("rst_clr", cnt_clr, 32'd0);
        chk("rst_pass", pass, 32'd0);
        chk("rst_err", err_count, 32'd0);
        reset = 1'b0;

        // len = 5 with a correct counter
        run_len(8'd5, 1'b0, 0, dc, ec, bc);
        chk("l5_done_cyc", dc, 32'd8);
        chk("l5_en_cyc", ec, 32'd5);
        chk("l5_busy_cyc", bc, 32'd8);
        chk("l5_pass", pass, 32'd1);
        chk("l5_count", count, 32'd5);
        @(negedge clk);
        chk("l5_done_pulse", done, 32'd0);
        chk("l5_busy_off", busy, 32'd0);
        chk("l5_err", err_count, 32'd0);

        // len = 0: no enable cycles
        run_len(8'd0, 1'b0, 0, dc, ec, bc);
        chk("l0_done_cyc", dc, 32'd3);
        chk("l0_en_cyc", ec, 32'd0);
        chk("l0_count", count, 32'd0);
        chk("l0_pass", pass, 32'd1);

        // len = 20 wraps the 4-bit counter
        run_len(8'd20, 1'b0, 0, dc, ec, bc);
        chk("l20_done_cyc", dc, 32'd23);
        chk("l20_en_cyc", ec, 32'd20);
        chk("l20_count", count, 32'd4);
        chk("l20_pass", pass, 32'd1);

        // start pulse and len change mid-run are ignored
        run_len(8'd7, 1'b0, 4, dc, ec, bc);
        chk("busy_done_cyc", dc, 32'd10);
        chk("busy_en_cyc", ec, 32'd7);
        chk("busy_count", count, 32'd7);
        chk("busy_pass", pass, 32'd1);
        @(negedge clk);
        chk("busy_no_requeue", busy, 32'd0);

        // reset in cycle 4 of a len = 10 run
        @(negedge clk);
        start = 1'b1;
        len   = 8'd10;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_en_before", cnt_en, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_en", cnt_en, 32'd0);
        chk("mid_rst_busy", busy, 32'd0);
        chk("mid_rst_clr", cnt_clr, 32'd0);
        chk("mid_rst_done", done, 32'd0);
        chk("mid_rst_pass", pass, 32'd0);
        chk("mid_rst_err", err_count, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        run_len(8'd3, 1'b0, 0, dc, ec, bc);
        chk("post_rst_done_cyc", dc, 32'd6);
        chk("post_rst_pass", pass, 32'd1);
        chk("post_rst_count", count, 32'd3);

        // Faulty counter: one increment skipped during a len = 6 run
        run_len(8'd6, 1'b1, 0, dc, ec, bc);
        chk("flt_done_cyc", dc, 32'd9);
        chk("flt_count", count, 32'd5);
        chk("flt_pass", pass, 32'd0);
        chk("flt_mism", dut.mism_r, 32'd1);
        @(negedge clk);
        chk("flt_err1", err_count, 32'd1);

        // 256 failing runs in total: tally saturates at 255
        for (int i = 2; i <= 256; i++) begin
            run_len(8'd6, 1'b1, 0, dc, ec, bc);
            @(negedge clk);
            if (i == 255) chk("flt_err255", err_count, 32'd255);
        end
        chk("flt_err_sat", err_count, 32'd255);

        // A passing run after saturation leaves the tally alone
        run_len(8'd2, 1'b0, 0, dc, ec, bc);
        chk("sat_pass", pass, 32'd1);
        @(negedge clk);
        chk("sat_err_hold", err_count, 32'd255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
